regfile_write_queue: RTL

- Write-side feeder for the multi-port register file macro (4 write ports, W0..W3).
- Buffers up to DEPTH pending register writes accepted on two enqueue lanes.
- Drains up to 4 oldest entries per cycle onto the macro's W0..W3 port bundle. Never places two writes to the same address in one issue group.
- Provides a youngest-match lookup so read-side logic can forward pending data not yet in the array.

---
 rtl/regfile_wq_pkg.sv | 19 +
 rtl/regfile_wq_group_sel.sv | 44 ++++
 rtl/regfile_write_queue.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/regfile_wq_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wq_pkg
// Shared definitions for the register-file write queue: default address and
// data widths (matching the macro's W*_addr / W*_data), the number of macro
// write ports, and the queue entry record.
// ---------------------------------------------------------------------------
package regfile_wq_pkg;

    localparam int WQ_ADDR_W = 7;
    localparam int WQ_DATA_W = 9;
    localparam int WQ_DEPTH  = 8;
    localparam int NWPORTS   = 4;

    typedef struct packed {
        logic [WQ_ADDR_W-1:0] addr;
        logic [WQ_DATA_W-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/regfile_wq_group_sel.sv
// ---------------------------------------------------------------------------
// regfile_wq_group_sel
// Combinational issue-group sizing. Given the four oldest queue entries
// (candidates) it returns how many of them may be written to the macro in
// one cycle: the longest prefix of valid candidates in which no address
// repeats an earlier address of the same group.
// Ports:
//   i_cand_addr  : addresses of candidates 0..3 (0 = oldest)
//   i_cand_valid : candidate valid bits (always a prefix, i < count)
//   o_group_size : number of candidates in the issue group (0..4)
// ---------------------------------------------------------------------------
module regfile_wq_group_sel
    import regfile_wq_pkg::*;
#(
    parameter int ADDR_W = WQ_ADDR_W
) (
    input  logic [NWPORTS-1:0][ADDR_W-1:0] i_cand_addr,
    input  logic [NWPORTS-1:0]             i_cand_valid,
    output logic [2:0]                     o_group_size
);

    logic w_stop;
    logic w_conflict;

    // Grow the group candidate by candidate; the first invalid or repeated
    // address closes it, so a later distinct address can never slip past it.
    always_comb begin
        o_group_size = 3'd0;
        w_stop       = 1'b0;
        w_conflict   = 1'b0;
        for (int i = 0; i < NWPORTS; i++) begin
            w_conflict = 1'b0;
            for (int j = 0; j < i; j++) begin
                w_conflict = w_conflict | (i_cand_addr[j] == i_cand_addr[i]);
            end
            if (!w_stop && i_cand_valid[i] && !w_conflict) begin
                o_group_size = 3'(i + 1);
            end else begin
                w_stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// ---------------------------------------------------------------------------
// regfile_write_queue
// Write-side feeder for the 4-write-port register file macro. Pending writes
// are held in a circular buffer, accepted on two enqueue lanes (lane 1 is
// younger), and drained oldest-first up to four per cycle onto W0..W3 with
// no two same-address writes in one group. A youngest-match lookup lets the
// read side forward data that has not yet reached the array.
// Ports:
//   clock, reset              : clock, asynchronous active-high reset
//   enq0_* / enq1_*           : enqueue lanes (enq1 needs enq0_valid)
//   enq_ready                 : both lanes may be accepted this cycle
//   wr_allow                  : macro accepts writes this cycle
//   W0..W3_en/_addr/_data     : macro write port bundles
//   lookup_addr/_hit/_data    : forwarding query
//   count                     : occupied entries
// ---------------------------------------------------------------------------
module regfile_write_queue
    import regfile_wq_pkg::*;
#(
    parameter int DEPTH  = WQ_DEPTH,
    parameter int ADDR_W = WQ_ADDR_W,
    parameter int DATA_W = WQ_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enq0_valid,
    input  logic [ADDR_W-1:0]        enq0_addr,
    input  logic [DATA_W-1:0]        enq0_data,
    input  logic                     enq1_valid,
    input  logic [ADDR_W-1:0]        enq1_addr,
    input  logic [DATA_W-1:0]        enq1_data,
    output logic                     enq_ready,
    input  logic                     wr_allow,
    output logic                     W0_en,
    output logic                     W1_en,
    output logic                     W2_en,
    output logic                     W3_en,
    output logic [ADDR_W-1:0]        W0_addr,
    output logic [ADDR_W-1:0]        W1_addr,
    output logic [ADDR_W-1:0]        W2_addr,
    output logic [ADDR_W-1:0]        W3_addr,
    output logic [DATA_W-1:0]        W0_data,
    output logic [DATA_W-1:0]        W1_data,
    output logic [DATA_W-1:0]        W2_data,
    output logic [DATA_W-1:0]        W3_data,
    input  logic [ADDR_W-1:0]        lookup_addr,
    output logic                     lookup_hit,
    output logic [DATA_W-1:0]        lookup_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];

    logic [1:0]                     w_nenq;
    logic [2:0]                     w_ndeq;
    logic [2:0]                     w_group_size;
    logic [PTR_W-1:0]               w_cand_idx  [NWPORTS];
    logic [NWPORTS-1:0][ADDR_W-1:0] w_cand_addr;
    logic [NWPORTS-1:0]             w_cand_valid;
    logic [NWPORTS-1:0]             w_wen;

    // Readiness looks only at registered occupancy; a same-cycle drain earns no credit.
    assign enq_ready = (r_count <= CNT_W'(DEPTH - 2));
    assign count     = r_count;

    // Number of entries accepted this edge; lane 1 rides only with lane 0.
    always_comb begin
        if (enq_ready && enq0_valid) begin
            w_nenq = enq1_valid ? 2'd2 : 2'd1;
        end else begin
            w_nenq = 2'd0;
        end
    end

    // Present the four oldest entries as issue candidates.
    always_comb begin
        for (int i = 0; i < NWPORTS; i++) begin
            w_cand_idx[i]   = PTR_W'(r_head + PTR_W'(i));
            w_cand_addr[i]  = r_mem_addr[w_cand_idx[i]];
            w_cand_valid[i] = (CNT_W'(i) < r_count);
        end
    end

    regfile_wq_group_sel #(
        .ADDR_W (ADDR_W)
    ) u_group_sel (
        .i_cand_addr  (w_cand_addr),
        .i_cand_valid (w_cand_valid),
        .o_group_size (w_group_size)
    );

    // Port enables depend only on wr_allow and registered state, never on enq_*.
    always_comb begin
        for (int i = 0; i < NWPORTS; i++) begin
            w_wen[i] = wr_allow & (3'(i) < w_group_size);
        end
        w_ndeq = wr_allow ? w_group_size : 3'd0;
    end

    assign W0_en   = w_wen[0];
    assign W1_en   = w_wen[1];
    assign W2_en   = w_wen[2];
    assign W3_en   = w_wen[3];
    assign W0_addr = w_cand_addr[0];
    assign W1_addr = w_cand_addr[1];
    assign W2_addr = w_cand_addr[2];
    assign W3_addr = w_cand_addr[3];
    assign W0_data = r_mem_data[w_cand_idx[0]];
    assign W1_data = r_mem_data[w_cand_idx[1]];
    assign W2_data = r_mem_data[w_cand_idx[2]];
    assign W3_data = r_mem_data[w_cand_idx[3]];

    // Forwarding scan from oldest to youngest so the youngest match wins;
    // entries issuing this cycle are still pending and therefore searched.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < r_count) &&
                (r_mem_addr[PTR_W'(r_head + PTR_W'(i))] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = r_mem_data[PTR_W'(r_head + PTR_W'(i))];
            end else begin
                lookup_hit  = lookup_hit;
                lookup_data = lookup_data;
            end
        end
    end

    // Pointer and occupancy state; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= PTR_W'(r_head + PTR_W'(w_ndeq));
            r_tail  <= PTR_W'(r_tail + PTR_W'(w_nenq));
            r_count <= CNT_W'(r_count + CNT_W'(w_nenq) - CNT_W'(w_ndeq));
        end
    end

    // Entry storage is not reset; occupancy alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (w_nenq != 2'd0) begin
            r_mem_addr[r_tail] <= enq0_addr;
            r_mem_data[r_tail] <= enq0_data;
        end
        if (w_nenq == 2'd2) begin
            r_mem_addr[PTR_W'(r_tail + PTR_W'(1))] <= enq1_addr;
            r_mem_data[PTR_W'(r_tail + PTR_W'(1))] <= enq1_data;
        end
    end

endmodule
